// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one pipelined unsigned WIDTH x WIDTH multiplier
// among NUM_REQ requesters using a round-robin pointer.
// Latency: request handshake in cycle 0, rsp_valid in cycle 2+MULT_LATENCY.
// Backpressure: one op per requester at a time; a requester is not granted while
//   its op is in flight or its response slot is unread. The pipe never stalls.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester operand handshake (ready is one-hot or zero)
//   req_a, req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready    per-requester product handshake
//   rsp_p                  packed products, requester i at [i*2*WIDTH +: 2*WIDTH]
//   mult_in1, mult_in2     registered operands to the external multiplier
//   mult_out               external multiplier product
//   busy                   any op in flight or any response pending
module mult_share_arbiter #(
    parameter int WIDTH        = 27,
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [NUM_REQ*2*WIDTH-1:0] rsp_p,
    output logic [WIDTH-1:0]           mult_in1,
    output logic [WIDTH-1:0]           mult_in2,
    input  logic [2*WIDTH-1:0]         mult_out,
    output logic                       busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = MULT_LATENCY + 1;
    localparam int PW    = 2 * WIDTH;

    // Registered state
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IDX_W-1:0] tag_q [DEPTH];
    logic [IDX_W-1:0] tag_d [DEPTH];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]    rsp_p_q [NUM_REQ];
    logic [PW-1:0]    rsp_p_d [NUM_REQ];

    // Arbitration signals
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               grant_en;

    // A requester is pending from issue until its response is consumed; the
    // stage-0 entry of the tag pipe coincides with the issue register.
    always_comb begin
        pending = rsp_valid_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (vld_q[s]) begin
                pending[tag_q[s]] = 1'b1;
            end
        end
        eligible = req_valid & ~pending;
    end

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_vld && eligible[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    // No grant is offered while reset is asserted.
    assign grant_en = grant_vld & ~rst;

    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        ptr_d = ptr_q;
        in1_d = in1_q;
        in2_d = in2_q;
        if (grant_en) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            in1_d = req_a[grant_idx*WIDTH +: WIDTH];
            in2_d = req_b[grant_idx*WIDTH +: WIDTH];
        end

        vld_d[0] = grant_en;
        tag_d[0] = grant_idx;
        for (int s = 1; s < DEPTH; s++) begin
            vld_d[s] = vld_q[s-1];
            tag_d[s] = tag_q[s-1];
        end

        // The last tag stage lines up with the cycle mult_out carries that op.
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = rsp_valid_q[i] & ~rsp_ready[i];
            rsp_p_d[i]     = rsp_p_q[i];
            if (vld_q[DEPTH-1] && (tag_q[DEPTH-1] == IDX_W'(i))) begin
                rsp_valid_d[i] = 1'b1;
                rsp_p_d[i]     = mult_out;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            vld_q       <= '0;
            rsp_valid_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_p_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            vld_q       <= vld_d;
            rsp_valid_q <= rsp_valid_d;
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= tag_d[s];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_p_q[i] <= rsp_p_d[i];
            end
        end
    end

    // Outputs
    always_comb begin
        rsp_p = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_p[i*PW +: PW] = rsp_p_q[i];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign mult_in1  = in1_q;
    assign mult_in2  = in2_q;
    assign busy      = (|vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a two-stage pipelined multiplier
// model attached; expected values are hand-computed constants.
module tb_mult_share_arbiter;

    localparam int W  = 27;
    localparam int N  = 4;
    localparam int L  = 2;
    localparam int PW = 2 * W;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [N*PW-1:0]  rsp_p;
    logic [W-1:0]     mult_in1;
    logic [W-1:0]     mult_in2;
    logic [PW-1:0]    mult_out;
    logic             busy;

    logic [PW-1:0]    m_s1, m_s2;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .MULT_LATENCY(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .mult_in1  (mult_in1),
        .mult_in2  (mult_in2),
        .mult_out  (mult_out),
        .busy      (busy)
    );

    // Pipelined multiplier, latency 2, sharing rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 <= '0;
            m_s2 <= '0;
        end else begin
            m_s1 <= PW'(mult_in1) * PW'(mult_in2);
            m_s2 <= m_s1;
        end
    end
    assign mult_out = m_s2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (failure %0d)", tag, got, exp, fails);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic logic [63:0] getp(input int i);
        return 64'(rsp_p[i*PW +: PW]);
    endfunction

    logic [3:0]  c_rr   [10];
    logic [3:0]  c_rv   [10];
    logic [63:0] c_prod [4];

    initial begin
        c_rr   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001,
                   4'b0000, 4'b0000, 4'b0000, 4'b0000};
        c_rv   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
                   4'b0100, 4'b1000, 4'b0000, 4'b0001};
        c_prod = '{64'd11, 64'd24, 64'd39, 64'd56};

        // ---- reset state, with all requesters asserting valid ----
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 4'b1111;
        sample();
        chk("rst req_ready", 64'(req_ready), 64'h0);
        chk("rst busy", 64'(busy), 64'h0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst mult_in1", 64'(mult_in1), 64'h0);

        // ---- priority from reset: req 1 then req 3 ----
        next_cyc();
        rst       = 1'b0;
        req_valid = 4'b1010;
        set_op(1, 27'd6, 27'd7);
        set_op(3, 27'd1000, 27'd1000);
        sample();
        chk("prio P0 req_ready", 64'(req_ready), 64'b0010);
        chk("prio P0 busy", 64'(busy), 64'h0);
        next_cyc();
        sample();
        chk("prio P1 req_ready", 64'(req_ready), 64'b1000);
        next_cyc();
        req_valid = 4'b0000;
        sample();
        chk("prio P2 req_ready", 64'(req_ready), 64'h0);
        next_cyc();
        sample();
        next_cyc();
        sample();
        chk("prio P4 rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("prio P4 rsp_p1", getp(1), 64'd42);
        next_cyc();
        sample();
        chk("prio P5 rsp_valid", 64'(rsp_valid), 64'b1000);
        chk("prio P5 rsp_p3", getp(3), 64'd1000000);
        next_cyc();
        sample();
        chk("prio P6 rsp_valid", 64'(rsp_valid), 64'h0);
        chk("prio P6 busy", 64'(busy), 64'h0);

        // ---- full contention: grants 0,1,2,3, gap, 0 ----
        for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(i + 11));
        for (int k = 0; k < 10; k++) begin
            next_cyc();
            req_valid = (k <= 5) ? 4'b1111 : 4'b0000;
            sample();
            chk($sformatf("cont C%0d req_ready", k), 64'(req_ready), 64'(c_rr[k]));
            chk($sformatf("cont C%0d rsp_valid", k), 64'(rsp_valid), 64'(c_rv[k]));
            for (int i = 0; i < N; i++) begin
                if (c_rv[k][i]) chk($sformatf("cont C%0d rsp_p%0d", k, i), getp(i), c_prod[i]);
            end
        end

        // ---- single op: 3*5 on req 0 ----
        next_cyc();
        req_valid = 4'b0001;
        set_op(0, 27'd3, 27'd5);
        sample();
        chk("single S0 req_ready", 64'(req_ready), 64'b0001);
        chk("single S0 busy", 64'(busy), 64'h0);
        next_cyc();
        req_valid = 4'b0000;
        sample();
        chk("single S1 mult_in1", 64'(mult_in1), 64'd3);
        chk("single S1 mult_in2", 64'(mult_in2), 64'd5);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin
                next_cyc();
                sample();
            end
            chk($sformatf("single S%0d busy", k), 64'(busy), 64'h1);
            chk($sformatf("single S%0d rsp_valid", k), 64'(rsp_valid), 64'h0);
        end
        next_cyc();
        sample();
        chk("single S4 rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("single S4 rsp_p0", getp(0), 64'd15);
        chk("single S4 busy", 64'(busy), 64'h1);
        next_cyc();
        sample();
        chk("single S5 rsp_valid", 64'(rsp_valid), 64'h0);
        chk("single S5 busy", 64'(busy), 64'h0);

        // ---- max operands on req 2 ----
        next_cyc();
        req_valid = 4'b0100;
        set_op(2, 27'h7FFFFFF, 27'h7FFFFFF);
        sample();
        chk("max M0 req_ready", 64'(req_ready), 64'b0100);
        next_cyc();
        req_valid = 4'b0000;
        sample();
        chk("max M1 mult_in1", 64'(mult_in1), 64'h7FFFFFF);
        next_cyc();
        sample();
        next_cyc();
        sample();
        next_cyc();
        sample();
        chk("max M4 rsp_valid", 64'(rsp_valid), 64'b0100);
        chk("max M4 rsp_p2", getp(2), 64'h3FFFFFF0000001);
        chk("max M4 rsp_p0 retained", getp(0), 64'd15);
        next_cyc();
        sample();
        chk("max M5 busy", 64'(busy), 64'h0);

        // ---- backpressure on req 1 ----
        next_cyc();
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        set_op(1, 27'd9, 27'd9);
        set_op(0, 27'd2, 27'd3);
        sample();
        chk("bp B0 req_ready", 64'(req_ready), 64'b0010);
        for (int j = 1; j <= 3; j++) begin
            next_cyc();
            sample();
            chk($sformatf("bp B%0d req_ready", j), 64'(req_ready), 64'h0);
            chk($sformatf("bp B%0d rsp_valid1", j), 64'(rsp_valid[1]), 64'h0);
        end
        for (int k = 0; k < 10; k++) begin
            next_cyc();
            if (k == 0) req_valid = 4'b0011;
            sample();
            chk($sformatf("bp B%0d rsp_valid1", k + 4), 64'(rsp_valid[1]), 64'h1);
            chk($sformatf("bp B%0d rsp_p1", k + 4), getp(1), 64'd81);
            chk($sformatf("bp B%0d req_ready", k + 4), 64'(req_ready),
                (k == 0 || k == 5) ? 64'b0001 : 64'h0);
        end
        next_cyc();
        rsp_ready = 4'b1111;
        sample();
        chk("bp B14 req_ready", 64'(req_ready), 64'b0001);
        chk("bp B14 rsp_valid1", 64'(rsp_valid[1]), 64'h1);
        next_cyc();
        req_valid = 4'b0010;
        sample();
        chk("bp B15 req_ready", 64'(req_ready), 64'b0010);
        chk("bp B15 rsp_valid1", 64'(rsp_valid[1]), 64'h0);
        next_cyc();
        req_valid = 4'b0000;
        sample();
        next_cyc();
        sample();
        next_cyc();
        sample();
        chk("bp B18 rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("bp B18 rsp_p0", getp(0), 64'd6);
        next_cyc();
        sample();
        chk("bp B19 rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("bp B19 rsp_p1", getp(1), 64'd81);
        next_cyc();
        sample();
        chk("bp B20 busy", 64'(busy), 64'h0);

        // ---- reset mid-flight ----
        next_cyc();
        req_valid = 4'b0001;
        set_op(0, 27'd5, 27'd5);
        sample();
        chk("mid R0 req_ready", 64'(req_ready), 64'b0001);
        next_cyc();
        req_valid = 4'b0000;
        sample();
        chk("mid R1 busy", 64'(busy), 64'h1);
        chk("mid R1 mult_in1", 64'(mult_in1), 64'd5);
        next_cyc();
        rst       = 1'b1;
        req_valid = 4'b1111;
        sample();
        chk("mid R2 req_ready", 64'(req_ready), 64'h0);
        chk("mid R2 busy", 64'(busy), 64'h0);
        chk("mid R2 rsp_valid", 64'(rsp_valid), 64'h0);
        chk("mid R2 mult_in1", 64'(mult_in1), 64'h0);
        chk("mid R2 mult_in2", 64'(mult_in2), 64'h0);
        chk("mid R2 rsp_p nonzero", 64'(rsp_p != '0), 64'h0);
        next_cyc();
        rst       = 1'b0;
        req_valid = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk($sformatf("mid post%0d rsp_valid", k), 64'(rsp_valid), 64'h0);
            chk($sformatf("mid post%0d busy", k), 64'(busy), 64'h0);
            next_cyc();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one pipelined unsigned WIDTH×WIDTH multiplier among NUM_REQ requesters. Each requester issues operands over a valid/ready handshake and receives its full-width product in a one-entry response buffer with its own valid/ready handshake. The block drives the multiplier's operand inputs from an issue register and tracks requester tags through a shift register matched to the multiplier latency. It sits between the consumers of the multiplier and the multiplier instance itself.

## Interface
- WIDTH, 27, operand width; product is 2*WIDTH.
- NUM_REQ, 4, number of requesters (≥2).
- MULT_LATENCY, 2, multiplier input-to-output latency in cycles; must match the attached multiplier.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_a, req_b  in  NUM_REQ*WIDTH  packed operands; requester i occupies bits [i*WIDTH +: WIDTH].
- rsp_valid  out  NUM_REQ  per-requester product valid.
- rsp_ready  in  NUM_REQ  per-requester product accept.
- rsp_p  out  NUM_REQ*2*WIDTH  packed products; requester i occupies bits [i*2*WIDTH +: 2*WIDTH].
- mult_in1, mult_in2  out  WIDTH  registered operands to the multiplier.
- mult_out  in  2*WIDTH  multiplier product.
- busy  out  1  high when any operation is in flight or any rsp_valid is high.

## Operation
- pending[i] = (an op tagged i is in the issue register or tag pipe) | rsp_valid[i]; computed from registered state only.
- eligible[i] = req_valid[i] & ~pending[i].
- Arbitration: combinational search for the first eligible index starting at ptr and wrapping modulo NUM_REQ. req_ready drives that single index high, or all zero if none are eligible. req_ready may depend on req_valid.
- On grant g: issue register <= {req_a[g], req_b[g]}, tag pipe stage 0 <= {valid=1, tag=g}, ptr <= (g+1) mod NUM_REQ. With no grant, ptr is held and stage 0 valid <= 0.
- mult_in1/mult_in2 hold their last issued value when idle.
- Tag pipe: depth MULT_LATENCY+1, advances every cycle with no stalls. When the last stage is valid with tag t, mult_out is valid that cycle: rsp_p[t] <= mult_out and rsp_valid[t] <= 1.
- Response: rsp_valid[i] clears on the cycle after rsp_valid[i] & rsp_ready[i]. rsp_p[i] is held stable while rsp_valid[i] is high and retains its value afterward.
- The pending rule guarantees at most one outstanding op per requester. The tag-pipe write to slot i therefore never coincides with a valid slot i, and no stall or overflow case exists.
- Arithmetic: unsigned, full 2*WIDTH product, no truncation.
- busy = |stage valids | |rsp_valid.
- Reset (any time, including mid-operation): ptr=0, all tag-pipe valids 0, rsp_valid=0, rsp_p=0, mult_in1=mult_in2=0, busy=0, req_ready=0 while rst is high. In-flight ops are discarded and no response emerges after release. The attached multiplier shares rst.

## Timing
- Handshake in cycle 0 → operands on mult_in in cycle 1 → mult_out valid in cycle 1+MULT_LATENCY → rsp_valid high in cycle 2+MULT_LATENCY (cycle 4 for defaults).
- Aggregate throughput is one issue per cycle.
- Per-requester throughput with rsp_ready held high is one op every MULT_LATENCY+3 cycles: the requester is next eligible the cycle after its response handshake.
- The only combinational paths are req_valid→req_ready; rsp_ready affects state only.

## Test plan
- Single op: req 0 with a=3, b=5 in cycle 0, rsp_ready=1 → req_ready[0]=1 in cycle 0, rsp_valid[0]=1 in cycle 4 only, rsp_p[0]=15, busy high cycles 1–4.
- Max operands: a=b=0x7FFFFFF on req 2 → rsp_p[2]=0x3FFFFFF0000001.
- Full contention: all four req_valid held high, rsp_ready=1 → grants 0,1,2,3 in cycles 0–3, no grant in cycle 4, grant 0 in cycle 5. Each product is correct and lands in the correct slot.
- Priority from reset: req 1 and req 3 valid in the first cycle after reset → 1 granted, then 3 the next cycle; ptr ends at 0.
- Backpressure: rsp_ready[1]=0 for 10 cycles after rsp_valid[1] rises → rsp_valid[1] and rsp_p[1] stay stable and req_ready[1] stays 0 while req 1 remains valid. Other requesters keep being granted. After release, a new grant to req 1 occurs no earlier than the cycle after the handshake.
- Reset mid-flight: grant req 0 in cycle 0, assert rst in cycle 2 for 1 cycle → all outputs return to reset values and no rsp_valid rises during the 10 cycles after release.
